// File: rtl/im_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into 32-bit
// words, writes them to the IM write port and holds the CPU in reset meanwhile.
module im_loader #(
  parameter int WORDS  = 256,
  parameter int WIDX_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDX_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err_overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [WIDX_W:0] WORDS_L   = (WIDX_W+1)'(WORDS);
  localparam logic [WIDX_W:0] COUNT_ONE = (WIDX_W+1)'(1);

  state_t            state;
  state_t            next_state;
  logic [WIDX_W-1:0] widx;
  logic [1:0]        bidx;
  logic [WIDX_W:0]   count;
  logic [31:0]       word;

  logic byte_fire;
  logic last_word;
  logic start_zero;
  logic start_ovf;

  assign byte_fire  = byte_valid && byte_ready;
  assign last_word  = ({1'b0, widx} + COUNT_ONE) == count;
  assign start_zero = (word_count == '0);
  assign start_ovf  = (word_count > WORDS_L);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every output and next_state gets a default first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    busy       = 1'b0;
    cpu_hold   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (start_zero || start_ovf) next_state = DONE;
          else                         next_state = RECV;
        end
      end
      RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        cpu_hold   = 1'b1;
        if (byte_fire && bidx == 2'd3) next_state = WRITE;
      end
      WRITE: begin
        mem_we     = 1'b1;
        busy       = 1'b1;
        cpu_hold   = 1'b1;
        next_state = last_word ? DONE : RECV;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath. start is only honoured in IDLE, so a pulse mid-load cannot
  // disturb the latched count or the indices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      widx         <= '0;
      bidx         <= '0;
      count        <= '0;
      word         <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        count        <= word_count;
        err_overflow <= start_ovf;
        widx         <= '0;
        bidx         <= '0;
      end

      if (byte_fire) begin
        word <= {word[23:0], byte_data};
        bidx <= bidx + 2'd1;
        // Write port is loaded here so address and data are stable for the
        // whole WRITE cycle and hold afterwards.
        if (bidx == 2'd3) begin
          mem_wdata <= {word[23:0], byte_data};
          mem_addr  <= {{(30-WIDX_W){1'b0}}, widx, 2'b00};
        end
      end

      if (state == WRITE) begin
        bidx <= '0;
        if (!last_word) widx <= widx + WIDX_W'(1);
      end
    end
  end

endmodule
